// File: rtl/video_pkg.sv
// video_pkg: definitions shared between the palette RAM controller and the
// video palette mux.
//   PAL_AW / PAL_DW / PAL_ENTRIES : user palette geometry (64 x BGR555)
//   pal_state_t                   : palette download FSM states
//   rgb555_t                      : BGR555 field slices (B [14:10], G [9:5], R [4:0])
package video_pkg;

   localparam int unsigned PAL_AW      = 6;
   localparam int unsigned PAL_DW      = 15;
   localparam int unsigned PAL_ENTRIES = 1 << PAL_AW;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMMIT,
      FINISH
   } pal_state_t;

   typedef struct packed {
      logic [4:0] b;
      logic [4:0] g;
      logic [4:0] r;
   } rgb555_t;

endpackage

// File: rtl/spram_64x15.sv
// spram_64x15: single-port synchronous RAM with registered read output.
//   clk   : clock
//   reset : synchronous active-high, clears only the read register
//   we    : write enable (caller guarantees we and re are never both high)
//   re    : read enable; rdata holds its value while re is low
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data, valid the cycle after re
module spram_64x15 #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1 << AW) - 1];

   // Contents are deliberately left uninitialised and untouched by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/palette_ram_ctrl.sv
// palette_ram_ctrl: owns the 64x15 user palette RAM, arbitrating it between
// the per-pixel video lookup (always wins) and the OSD/HPS download stream
// (writes deferred to free cycles with back-pressure). Tracks load progress
// and flags when a complete custom palette is present.
//   clk, reset : clock, synchronous active-high reset
//   rd_en      : video read request (pixel strobe)
//   rd_idx     : colour index to read
//   rd_data    : entry read back, valid the cycle after rd_en, held otherwise
//   dl_active  : palette download in progress
//   dl_wr      : download byte strobe
//   dl_addr    : byte address within the download
//   dl_data    : byte value
//   dl_wait    : back-pressure to the downloader
//   pal_valid  : a complete custom palette is loaded
//   dl_err     : sticky error (overrun, sequence error, short load)
import video_pkg::*;

module palette_ram_ctrl #(
   parameter int unsigned ENTRIES = PAL_ENTRIES,
   parameter int unsigned AW      = PAL_AW,
   parameter int unsigned DW      = PAL_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [DW-1:0] rd_data,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [7:0]    dl_addr,
   input  logic [7:0]    dl_data,
   output logic          dl_wait,
   output logic          pal_valid,
   output logic          dl_err
);

   localparam logic [8:0]  BYTE_LIMIT = 9'(2 * ENTRIES);
   localparam logic [AW:0] CNT_FULL   = (AW + 1)'(ENTRIES);

   pal_state_t     state;
   logic           dl_active_q;
   logic [AW-1:0]  idx;
   logic [7:0]     lo;
   logic [DW-9:0]  hi;
   logic           lo_ok;
   logic [AW:0]    cnt;

   logic           in_range;
   logic           is_odd;
   logic           hi_match;
   logic           hi_accept;
   logic           ram_we;
   logic [AW-1:0]  ram_addr;
   logic [DW-1:0]  ram_wdata;
   logic           unused_hi_msb;

   always_comb begin
      in_range      = ({1'b0, dl_addr} < BYTE_LIMIT);
      is_odd        = dl_addr[0];
      hi_match      = lo_ok && (idx == dl_addr[AW:1]);
      hi_accept     = (state == LOAD) && dl_active && dl_wr && in_range && is_odd && hi_match;
      // Asserted in the accepting cycle too, so the downloader never gets a
      // second strobe in before COMMIT is visible.
      dl_wait       = (state == COMMIT) || hi_accept;
      // Reads own the port outright; a pending write just waits.
      ram_we        = (state == COMMIT) && !rd_en;
      ram_addr      = rd_en ? rd_idx : idx;
      ram_wdata     = {hi, lo};
      unused_hi_msb = dl_data[7];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         dl_active_q <= 1'b0;
         idx         <= '0;
         lo          <= '0;
         hi          <= '0;
         lo_ok       <= 1'b0;
         cnt         <= '0;
         pal_valid   <= 1'b0;
         dl_err      <= 1'b0;
      end else begin
         dl_active_q <= dl_active;
         case (state)
            IDLE: begin
               if (dl_active && !dl_active_q) begin
                  pal_valid <= 1'b0;
                  dl_err    <= 1'b0;
                  cnt       <= '0;
                  lo_ok     <= 1'b0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               // dl_active can only be low here after a falling edge.
               if (!dl_active) begin
                  state <= FINISH;
               end else if (dl_wr && in_range) begin
                  if (!is_odd) begin
                     lo    <= dl_data;
                     idx   <= dl_addr[AW:1];
                     lo_ok <= 1'b1;
                  end else if (hi_match) begin
                     hi    <= dl_data[DW-9:0];
                     lo_ok <= 1'b0;
                     state <= COMMIT;
                  end else begin
                     dl_err <= 1'b1;
                  end
               end
            end
            COMMIT: begin
               if (dl_wr) begin
                  dl_err <= 1'b1;
               end
               if (!rd_en) begin
                  if (({1'b0, idx} == cnt) && (cnt != CNT_FULL)) begin
                     cnt <= cnt + 1'b1;
                  end
                  // A falling edge seen during COMMIT is honoured here, after
                  // the write has gone in.
                  state <= dl_active ? LOAD : FINISH;
               end
            end
            FINISH: begin
               if ((cnt == CNT_FULL) && !dl_err) begin
                  pal_valid <= 1'b1;
               end else begin
                  dl_err <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   spram_64x15 #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .re    (rd_en),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// tb_palette_ram_ctrl: directed bench for palette_ram_ctrl covering full
// load, read/write contention, short load, sequence error, overrun and
// reset during a download.
import video_pkg::*;

module tb_palette_ram_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       rd_en;
   logic [5:0] rd_idx;
   logic [14:0] rd_data;
   logic       dl_active;
   logic       dl_wr;
   logic [7:0] dl_addr;
   logic [7:0] dl_data;
   logic       dl_wait;
   logic       pal_valid;
   logic       dl_err;

   int checks   = 0;
   int failures = 0;

   palette_ram_ctrl #(
      .ENTRIES (64),
      .AW      (6),
      .DW      (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .dl_active (dl_active),
      .dl_wr     (dl_wr),
      .dl_addr   (dl_addr),
      .dl_data   (dl_data),
      .dl_wait   (dl_wait),
      .pal_valid (pal_valid),
      .dl_err    (dl_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
      end
   endtask

   // Palette patterns: 0 is 0x0421*k, 1 and 2 are arbitrary distinct fills.
   function automatic logic [14:0] pat(input int sel, input int k);
      logic [31:0] v;
      case (sel)
         0:       v = 32'h0421 * k;
         1:       v = 32'h0123 * k + 32'h0100;
         default: v = 32'h2A55 ^ (32'h0051 * k);
      endcase
      return v[14:0];
   endfunction

   // Strobe one byte, then honour back-pressure before returning.
   task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
      int w;
      @(negedge clk);
      dl_wr   = 1'b1;
      dl_addr = a;
      dl_data = d;
      @(negedge clk);
      dl_wr = 1'b0;
      #1;
      w = 0;
      while (dl_wait && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (dl_wait) check("wait_timeout", 32'(dl_wait), 32'd0);
   endtask

   task automatic wr_entry(input int k, input logic [14:0] v, input logic hi7);
      wr_byte(8'(2 * k), v[7:0]);
      wr_byte(8'(2 * k + 1), {hi7, v[14:8]});
   endtask

   task automatic start_dl();
      @(negedge clk);
      dl_active = 1'b1;
      @(negedge clk);
   endtask

   task automatic end_dl();
      @(negedge clk);
      dl_active = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic rd(input int i, output logic [14:0] v);
      @(negedge clk);
      rd_en  = 1'b1;
      rd_idx = 6'(i);
      @(negedge clk);
      v     = rd_data;
      rd_en = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [14:0] v;
      int nw;

      reset = 1'b1; rd_en = 1'b0; rd_idx = '0; dl_active = 1'b0;
      dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_wait", 32'(dl_wait), 32'd0);
      check("rst_valid", 32'(pal_valid), 32'd0);
      check("rst_err", 32'(dl_err), 32'd0);

      // Full load with an out-of-range byte in the middle.
      start_dl();
      for (int k = 0; k < 64; k++) begin
         wr_entry(k, pat(0, k), 1'b0);
         if (k == 30) begin
            @(negedge clk);
            dl_wr = 1'b1; dl_addr = 8'd200; dl_data = 8'hAA;
            #1;
            check("oor_nowait", 32'(dl_wait), 32'd0);
            @(negedge clk);
            dl_wr = 1'b0;
         end
      end
      check("full_valid_during", 32'(pal_valid), 32'd0);
      end_dl();
      check("full_valid", 32'(pal_valid), 32'd1);
      check("full_err", 32'(dl_err), 32'd0);
      for (int k = 0; k < 64; k++) begin
         rd(k, v);
         check($sformatf("full_rd%0d", k), 32'(v), 32'(pat(0, k)));
      end

      // Contention: reads on idx 5 from the high-byte strobe for 3 cycles.
      start_dl();
      check("reload_valid_clr", 32'(pal_valid), 32'd0);
      wr_byte(8'd10, 8'hFF);
      @(negedge clk);
      dl_wr = 1'b1; dl_addr = 8'd11; dl_data = 8'h7F; rd_en = 1'b1; rd_idx = 6'd5;
      #1;
      nw = dl_wait ? 1 : 0;
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         if (c <= 3) check($sformatf("hold_rd%0d", c), 32'(rd_data), 32'(pat(0, 5)));
         if (c == 1) dl_wr = 1'b0;
         if (c == 3) rd_en = 1'b0;
         #1;
         if (dl_wait) nw++;
      end
      check("cont_wait_cycles", 32'(nw), 32'd4);
      rd(5, v);
      check("cont_new5", 32'(v), 32'h7FFF);
      end_dl();
      check("cont_valid", 32'(pal_valid), 32'd0);
      check("cont_err", 32'(dl_err), 32'd1);

      // Short load: 100 bytes.
      start_dl();
      for (int k = 0; k < 50; k++) wr_entry(k, pat(1, k), 1'b0);
      end_dl();
      check("short_valid", 32'(pal_valid), 32'd0);
      check("short_err", 32'(dl_err), 32'd1);
      for (int k = 0; k < 50; k++) begin
         rd(k, v);
         check($sformatf("short_rd%0d", k), 32'(v), 32'(pat(1, k)));
      end
      rd(50, v);
      check("short_rd50_old", 32'(v), 32'(pat(0, 50)));

      // Sequence error: odd byte with no preceding low byte.
      start_dl();
      check("seq_err_clr", 32'(dl_err), 32'd0);
      wr_byte(8'd3, 8'h11);
      check("seq_err", 32'(dl_err), 32'd1);
      end_dl();
      rd(1, v);
      check("seq_rd1", 32'(v), 32'(pat(1, 1)));
      start_dl();
      for (int k = 0; k < 64; k++) wr_entry(k, pat(0, k), 1'b1);
      end_dl();
      check("reload_valid", 32'(pal_valid), 32'd1);
      check("reload_err", 32'(dl_err), 32'd0);
      rd(1, v);  check("reload_rd1", 32'(v), 32'(pat(0, 1)));
      rd(49, v); check("reload_rd49", 32'(v), 32'(pat(0, 49)));
      rd(63, v); check("reload_rd63", 32'(v), 32'(pat(0, 63)));

      // Overrun: strobe held into COMMIT carries a low byte that must drop.
      start_dl();
      wr_byte(8'd0, 8'h34);
      @(negedge clk);
      dl_wr = 1'b1; dl_addr = 8'd1; dl_data = 8'h12;
      @(negedge clk);
      dl_addr = 8'd2; dl_data = 8'h55;
      @(negedge clk);
      dl_wr = 1'b0;
      check("ovr_err", 32'(dl_err), 32'd1);
      wr_byte(8'd3, 8'h66);
      end_dl();
      check("ovr_valid", 32'(pal_valid), 32'd0);
      check("ovr_err_final", 32'(dl_err), 32'd1);
      rd(0, v);
      check("ovr_rd0", 32'(v), 32'h1234);
      rd(1, v);
      check("ovr_rd1", 32'(v), 32'(pat(0, 1)));

      // Reset after 40 bytes of a new download.
      start_dl();
      for (int k = 0; k < 20; k++) wr_entry(k, pat(2, k), 1'b0);
      @(negedge clk);
      reset = 1'b1; dl_active = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_state", 32'(dut.state), 32'(IDLE));
      check("rstmid_wait", 32'(dl_wait), 32'd0);
      check("rstmid_valid", 32'(pal_valid), 32'd0);
      check("rstmid_err", 32'(dl_err), 32'd0);
      for (int k = 0; k < 20; k++) begin
         rd(k, v);
         check($sformatf("rstmid_rd%0d", k), 32'(v), 32'(pat(2, k)));
      end
      rd(20, v);
      check("rstmid_rd20", 32'(v), 32'(pat(0, 20)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/palette_ram_ctrl.md
Name: palette_ram_ctrl

Overview:
- Owns a single-port 64x15 user-palette RAM.
- Arbitrates that RAM between two sides:
  - the video palette lookup, a read once per pixel strobe;
  - the OSD/HPS file-download stream, which writes a custom palette byte by byte.
- Video reads always win. Download writes are deferred to free cycles, with back-pressure on the downloader.
- Tracks load progress and raises a "custom palette valid" flag that the video palette mux uses to select the user palette.

Parameters:
- ENTRIES, 64: number of palette entries.
- AW, 6: entry index width; ENTRIES equals 2**AW.
- DW, 15: entry width, BGR555 (B in [14:10], G in [9:5], R in [4:0]).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- rd_en, input, 1: video read request; pulses on the pixel strobe (pix_ce_n).
- rd_idx, input, AW: colour index to read.
- rd_data, output, DW: entry read back; valid the cycle after rd_en.
- dl_active, input, 1: palette download in progress (ioctl_download gated by index).
- dl_wr, input, 1: byte strobe.
- dl_addr, input, 8: byte address within the download.
- dl_data, input, 8: byte value.
- dl_wait, output, 1: back-pressure; the downloader must not strobe while this is high.
- pal_valid, output, 1: a complete custom palette is loaded.
- dl_err, output, 1: sticky error (overrun, sequence error, or short load).

Behaviour:
- Reset:
  - rd_data=0, dl_wait=0, pal_valid=0, dl_err=0.
  - FSM returns to IDLE; entry counter and latches are cleared.
  - RAM contents are not cleared.
  - A reset in mid-download abandons the download, and pal_valid stays 0.
- Byte format:
  - Entry k is held at bytes 2k (low byte) and 2k+1 (high byte).
  - entry = {hi[6:0], lo}; hi[7] is ignored.
  - Bytes with dl_addr >= 2*ENTRIES are accepted without wait and discarded.
- FSM states:
  - IDLE
    - Rising edge of dl_active: clear pal_valid, dl_err and the entry counter; go to LOAD.
  - LOAD
    - dl_wr on an even address: latch lo and idx=dl_addr[AW:1]; set lo_ok.
    - dl_wr on an odd address with lo_ok and a matching idx: latch hi, clear lo_ok, go to COMMIT.
    - Odd address without a matching lo: drop the byte and set dl_err.
    - Falling edge of dl_active: go to FINISH.
  - COMMIT
    - dl_wait=1 for the whole state.
    - On the first cycle with rd_en=0: write RAM[idx]; increment the entry counter if idx equals the counter (in-order load); go to LOAD.
    - If rd_en=1, the read is serviced and the write is held.
    - A falling edge of dl_active while in COMMIT: finish the write first, then go to FINISH.
  - FINISH (1 cycle)
    - Counter == ENTRIES and dl_err==0: set pal_valid.
    - Otherwise: set dl_err.
    - Go to IDLE.
- dl_wait combinational timing: dl_wait is asserted combinationally in the same cycle that a high byte is accepted, as well as throughout COMMIT.
- Overrun: dl_wr while in COMMIT drops the byte and sets dl_err.
- Read path:
  - rd_en at cycle N gives rd_data at N+1.
  - rd_data holds its value when rd_en=0.
  - Reads have absolute priority, so no read/write collision can occur.
- Write latency bound: with rd_en at most 1-in-4 duty, COMMIT lasts at most 2 cycles.
- Counter width: AW+1 bits, saturating at ENTRIES.
- Reloading: pal_valid is cleared for the entire duration of any new download, so the video side falls back to the built-in palettes while loading.

Decomposition:
- Shared package video_pkg:
  - PAL_AW=6, PAL_DW=15;
  - the palette state enum (IDLE, LOAD, COMMIT, FINISH);
  - an RGB555 field-slice typedef, shared with the palette mux.
- Sub-module: spram_64x15.
  - Single-port synchronous RAM with registered read.
  - Inferable as block RAM or MLAB.
- The FSM, arbitration and counters stay in palette_ram_ctrl.

Test Plan:
- Full load, no reads:
  - Stimulus: 128 bytes where entry k = 0x0421*k masked to 15 bits; dl_active then falls.
  - Required: pal_valid=1 and dl_err=0; reading idx 0..63 returns 0x0421*k.
- Contention:
  - Stimulus: rd_en held high for 3 cycles starting with the high-byte strobe of entry 5 = 0x7FFF.
  - Required:
    - dl_wait high for 4 cycles;
    - rd_data for idx 5 during the hold equals the old value;
    - after release, a read of idx 5 returns 0x7FFF.
- Short load:
  - Stimulus: only 100 bytes, then dl_active falls.
  - Required: pal_valid=0, dl_err=1; entries 0..49 are written.
- Sequence error:
  - Stimulus: byte at address 3 without byte 2 first.
  - Required: dl_err=1 and entry 1 unchanged; after a full reload, pal_valid=1 and dl_err=0.
- Overrun:
  - Stimulus: dl_wr strobed during COMMIT.
  - Required: byte dropped, dl_err=1, and FINISH leaves pal_valid=0.
- Reset mid-download:
  - Stimulus: reset after 40 bytes.
  - Required: FSM in IDLE, dl_wait=0, pal_valid=0, and entries 0..19 retain their values.
